// File: rtl/memshare_shift_gen.sv
// SHIFT_GEN stage of the memShare scheduler: turns absolute circulant shift factors
// into shifts relative to the previously applied one (delta FF), modulo Z.
module memshare_shift_gen #(
    parameter int unsigned Z            = 255,
    parameter int unsigned SHIFT_W      = $clog2(Z),
    parameter int unsigned COL_MAX      = 32,
    parameter int unsigned CNT_W        = $clog2(COL_MAX + 1),
    parameter logic        RST_POLARITY = 1'b0
) (
    input  logic               sys_clk,
    input  logic               rstn,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   col_num_i,
    input  logic [SHIFT_W-1:0] sh_i,
    input  logic               sh_valid_i,
    output logic               sh_ready_o,
    input  logic               delta_rst_i,
    output logic               isGtr_o,
    output logic               isGtr_vld_o,
    output logic [SHIFT_W-1:0] shift_o,
    output logic               shift_valid_o,
    input  logic               shift_ready_i,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_READ_COL_ADDR = 2'd1,
        ST_SHIFT_GEN     = 2'd2,
        ST_OUT_WAIT      = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SHIFT_W-1:0] delta_q, delta_d;
    logic [SHIFT_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   col_num_q, col_num_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   col_num_clamped;
    logic [SHIFT_W:0]   rel_shift;
    logic               gtr;

    logic               sh_ready_d, isgtr_d, isgtr_vld_d, shift_valid_d, busy_d, done_d;
    logic [SHIFT_W-1:0] shift_d;

    assign cnt_inc = cnt_q + CNT_W'(1);
    // Out-of-range column counts are clamped rather than left to wrap the counter.
    assign col_num_clamped = (col_num_i > CNT_W'(COL_MAX)) ? CNT_W'(COL_MAX) : col_num_i;

    // Relative shift, one extra bit so sh_q + Z cannot overflow.
    always_comb begin
        gtr = (delta_q > sh_q);
        if (gtr) begin
            rel_shift = {1'b0, sh_q} + (SHIFT_W+1)'(Z) - {1'b0, delta_q};
        end else begin
            rel_shift = {1'b0, sh_q} - {1'b0, delta_q};
        end
    end

    // Delta FF next value; the external clear beats the SHIFT_GEN load.
    always_comb begin
        delta_d = delta_q;
        if (delta_rst_i == RST_POLARITY) begin
            delta_d = '0;
        end else if (state_q == ST_SHIFT_GEN) begin
            delta_d = sh_q;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && (col_num_i != '0)) state_d = ST_READ_COL_ADDR;
            end
            ST_READ_COL_ADDR: begin
                if (sh_valid_i && sh_ready_o) state_d = ST_SHIFT_GEN;
            end
            ST_SHIFT_GEN: begin
                state_d = ST_OUT_WAIT;
            end
            ST_OUT_WAIT: begin
                if (shift_ready_i) begin
                    state_d = (cnt_inc == col_num_q) ? ST_IDLE : ST_READ_COL_ADDR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath registers.
    always_comb begin
        sh_ready_d    = 1'b0;
        isgtr_d       = 1'b0;
        isgtr_vld_d   = 1'b0;
        shift_d       = shift_o;
        shift_valid_d = 1'b0;
        done_d        = 1'b0;
        busy_d        = (state_d != ST_IDLE);
        sh_d          = sh_q;
        cnt_d         = cnt_q;
        col_num_d     = col_num_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (col_num_i != '0) begin
                        col_num_d  = col_num_clamped;
                        cnt_d      = '0;
                        sh_ready_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_READ_COL_ADDR: begin
                sh_ready_d = 1'b1;
                if (sh_valid_i && sh_ready_o) begin
                    sh_d        = sh_i;
                    sh_ready_d  = 1'b0;
                    // Look ahead so the registered flag reflects delta during SHIFT_GEN.
                    isgtr_d     = (delta_d > sh_i);
                    isgtr_vld_d = 1'b1;
                end
            end
            ST_SHIFT_GEN: begin
                shift_d       = SHIFT_W'(rel_shift);
                shift_valid_d = 1'b1;
            end
            ST_OUT_WAIT: begin
                shift_valid_d = 1'b1;
                if (shift_ready_i) begin
                    shift_valid_d = 1'b0;
                    cnt_d         = cnt_inc;
                    if (cnt_inc == col_num_q) begin
                        done_d = 1'b1;
                    end else begin
                        sh_ready_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            delta_q       <= '0;
            sh_q          <= '0;
            cnt_q         <= '0;
            col_num_q     <= '0;
            sh_ready_o    <= 1'b0;
            isGtr_o       <= 1'b0;
            isGtr_vld_o   <= 1'b0;
            shift_o       <= '0;
            shift_valid_o <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            delta_q       <= delta_d;
            sh_q          <= sh_d;
            cnt_q         <= cnt_d;
            col_num_q     <= col_num_d;
            sh_ready_o    <= sh_ready_d;
            isGtr_o       <= isgtr_d;
            isGtr_vld_o   <= isgtr_vld_d;
            shift_o       <= shift_d;
            shift_valid_o <= shift_valid_d;
            busy_o        <= busy_d;
            done_o        <= done_d;
        end
    end

endmodule

// File: tb/tb_memshare_shift_gen.sv
// Bench for memshare_shift_gen: directed scenarios plus random layers checked against
// a modulo-Z relative-shift model of the delta FF.
module tb_memshare_shift_gen;

    localparam int unsigned Z       = 255;
    localparam int unsigned SHIFT_W = 8;
    localparam int unsigned COL_MAX = 32;
    localparam int unsigned CNT_W   = 6;

    logic               sys_clk = 1'b0;
    logic               rstn = 1'b0;
    logic               start_i = 1'b0;
    logic [CNT_W-1:0]   col_num_i = '0;
    logic [SHIFT_W-1:0] sh_i = '0;
    logic               sh_valid_i = 1'b0;
    logic               sh_ready_o;
    logic               delta_rst_i = 1'b1;
    logic               isGtr_o;
    logic               isGtr_vld_o;
    logic [SHIFT_W-1:0] shift_o;
    logic               shift_valid_o;
    logic               shift_ready_i = 1'b0;
    logic               busy_o;
    logic               done_o;

    int checks = 0;
    int errors = 0;
    int m_delta = 0;

    memshare_shift_gen #(.Z(Z), .COL_MAX(COL_MAX), .RST_POLARITY(1'b0)) dut (
        .sys_clk(sys_clk), .rstn(rstn), .start_i(start_i), .col_num_i(col_num_i),
        .sh_i(sh_i), .sh_valid_i(sh_valid_i), .sh_ready_o(sh_ready_o),
        .delta_rst_i(delta_rst_i), .isGtr_o(isGtr_o), .isGtr_vld_o(isGtr_vld_o),
        .shift_o(shift_o), .shift_valid_o(shift_valid_o), .shift_ready_i(shift_ready_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (start_i) assert (col_num_i <= CNT_W'(COL_MAX)) else $error("col_num_i above COL_MAX");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start_layer(input int n);
        start_i = 1'b1;
        col_num_i = CNT_W'(n);
        tick();
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || sh_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL start busy/ready got %0b/%0b want 1/1", busy_o, sh_ready_o);
        end
    endtask

    // One column: handshake, SHIFT_GEN flag, OUT_WAIT with bp stall cycles, acceptance.
    task automatic do_col(input int sh, input int bp, input bit clr, input bit last);
        int  waited;
        bit  exp_gtr;
        int  exp_shift;
        waited = 0;
        while (sh_ready_o !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        if (sh_ready_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL sh_ready_timeout got %0b want 1", sh_ready_o);
            return;
        end
        sh_i = SHIFT_W'(sh);
        sh_valid_i = 1'b1;
        tick();
        sh_valid_i = 1'b0;
        exp_gtr = (m_delta > sh);
        exp_shift = (sh - m_delta + int'(Z)) % int'(Z);
        checks++;
        if (isGtr_o !== exp_gtr || isGtr_vld_o !== 1'b1 || sh_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL isgtr sh=%0d delta=%0d got gtr=%0b vld=%0b rdy=%0b want %0b/1/0",
                     sh, m_delta, isGtr_o, isGtr_vld_o, sh_ready_o, exp_gtr);
        end
        // Unrelated start during SHIFT_GEN must be ignored.
        start_i = $urandom_range(0, 1) == 1;
        col_num_i = CNT_W'(5);
        if (clr) delta_rst_i = 1'b0;
        tick();
        start_i = 1'b0;
        delta_rst_i = 1'b1;
        m_delta = clr ? 0 : sh;
        checks++;
        if (shift_valid_o !== 1'b1 || shift_o !== SHIFT_W'(exp_shift) || isGtr_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL shift sh=%0d got %0d vld=%0b want %0d vld=1", sh, shift_o, shift_valid_o, exp_shift);
        end
        for (int i = 0; i < bp; i++) begin
            tick();
            checks++;
            if (shift_valid_o !== 1'b1 || shift_o !== SHIFT_W'(exp_shift) || sh_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cyc=%0d got shift=%0d vld=%0b rdy=%0b want %0d/1/0",
                         i, shift_o, shift_valid_o, sh_ready_o, exp_shift);
            end
        end
        shift_ready_i = 1'b1;
        tick();
        shift_ready_i = 1'b0;
        checks++;
        if (done_o !== last || shift_valid_o !== 1'b0 || sh_ready_o !== !last || busy_o !== !last) begin
            errors++;
            $display("FAIL accept last=%0b got done=%0b vld=%0b rdy=%0b busy=%0b",
                     last, done_o, shift_valid_o, sh_ready_o, busy_o);
        end
        if (last) begin
            tick();
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse got done=%0b busy=%0b want 0/0", done_o, busy_o);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        m_delta = 0;
        checks++;
        if ({sh_ready_o, isGtr_o, isGtr_vld_o, shift_o, shift_valid_o, busy_o, done_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%0b gtr=%0b gv=%0b sh=%0d sv=%0b busy=%0b done=%0b want all 0",
                     sh_ready_o, isGtr_o, isGtr_vld_o, shift_o, shift_valid_o, busy_o, done_o);
        end
    endtask

    task automatic test_basic();
        start_layer(3);
        do_col(10, 0, 1'b0, 1'b0);
        do_col(40, 0, 1'b0, 1'b0);
        do_col(5, 0, 1'b0, 1'b1);
    endtask

    task automatic test_wrap_edges();
        start_layer(3);
        do_col(254, 0, 1'b0, 1'b0);
        do_col(0, 0, 1'b0, 1'b0);
        do_col(254, 0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        start_layer(2);
        do_col(100, 5, 1'b0, 1'b0);
        do_col(60, 0, 1'b0, 1'b1);
    endtask

    task automatic test_delta_clear();
        start_layer(2);
        do_col(77, 0, 1'b1, 1'b0);
        do_col(77, 0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_layer();
        start_layer(4);
        do_col(33, 0, 1'b0, 1'b0);
        sh_i = SHIFT_W'(90);
        sh_valid_i = 1'b1;
        tick();
        sh_valid_i = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        m_delta = 0;
        checks++;
        if ({sh_ready_o, isGtr_o, isGtr_vld_o, shift_o, shift_valid_o, busy_o, done_o} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got rdy=%0b sv=%0b sh=%0d busy=%0b done=%0b want all 0",
                     sh_ready_o, shift_valid_o, shift_o, busy_o, done_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_nodone got done=%0b busy=%0b want 0/0", done_o, busy_o);
        end
        start_layer(2);
        do_col(200, 1, 1'b0, 1'b0);
        do_col(150, 0, 1'b0, 1'b1);
    endtask

    task automatic test_zero_cols();
        start_i = 1'b1;
        col_num_i = '0;
        tick();
        start_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || sh_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_cols got done=%0b busy=%0b rdy=%0b want 1/0/0", done_o, busy_o, sh_ready_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || sh_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_cols_after got done=%0b busy=%0b rdy=%0b want 0/0/0", done_o, busy_o, sh_ready_o);
        end
    endtask

    task automatic test_random_layers();
        for (int l = 0; l < 8; l++) begin
            int n;
            n = int'($urandom_range(1, 6));
            start_layer(n);
            for (int c = 0; c < n; c++) begin
                int sh;
                sh = int'($urandom_range(0, Z - 1));
                if ($urandom_range(0, 3) == 0) sh = m_delta;
                do_col(sh, int'($urandom_range(0, 3)), $urandom_range(0, 4) == 0, c == n - 1);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_edges();
        test_backpressure();
        test_delta_clear();
        test_reset_mid_layer();
        test_zero_cols();
        test_random_layers();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memshare_shift_gen.md
Name: memshare_shift_gen

Overview:
- Runs the SHIFT_GEN stage of the memShare access-request scheduler, directly downstream of READ_COL_ADDR.
- Per layer, accepts a stream of circulant column shift factors and emits, for each one, the relative shift with respect to the delta FF (the previously applied shift), modulo Z.
- Owns the delta FF and produces isGtr_o, the wrap-around flag, for the external delta-reset generator.
- Consumes that generator's synchronous reset back as delta_rst_i.

Parameters:
- Z, 255, circulant (lifting) size; all shift factors lie in [0, Z-1].
- SHIFT_W, $clog2(Z), width of shift factors and delta.
- COL_MAX, 32, maximum columns per layer.
- CNT_W, $clog2(COL_MAX+1), width of the column count.
- RST_POLARITY, 1'b0, level of delta_rst_i that clears the delta FF (0: active low, 1: active high).

Ports:
- sys_clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- start_i  in  1  layer start pulse; accepted only in IDLE
- col_num_i  in  CNT_W  columns in this layer; sampled with start_i
- sh_i  in  SHIFT_W  column shift factor from READ_COL_ADDR
- sh_valid_i  in  1  sh_i valid
- sh_ready_o  out  1  ready for sh_i
- delta_rst_i  in  1  synchronous clear for the delta FF, from the delta-reset generator
- isGtr_o  out  SHIFT_W>0?1:1  wrap flag, meaning delta_q > shift factor; valid while in SHIFT_GEN
- isGtr_vld_o  out  1  one-cycle strobe qualifying isGtr_o
- shift_o  out  SHIFT_W  relative shift to downstream
- shift_valid_o  out  1  shift_o valid
- shift_ready_i  in  1  downstream ready
- busy_o  out  1  high whenever not in IDLE
- done_o  out  1  one-cycle pulse when the last column's shift is accepted

Behaviour:
- Reset (rstn=0 at a clock edge):
  - state=IDLE, delta_q=0, column counter=0, stored col_num=0.
  - All outputs 0: sh_ready_o, isGtr_o, isGtr_vld_o, shift_o, shift_valid_o, busy_o, done_o.
  - Reset mid-layer aborts the layer immediately; no done_o is produced.
- FSM states: IDLE, READ_COL_ADDR, SHIFT_GEN, OUT_WAIT.
- IDLE:
  - start_i=1 with col_num_i>0: latch col_num_i, clear the counter, go to READ_COL_ADDR.
  - start_i=1 with col_num_i=0: pulse done_o next cycle, stay in IDLE.
  - start_i is ignored in all other states.
- READ_COL_ADDR:
  - sh_ready_o=1 (registered, asserted on entry).
  - On sh_valid_i & sh_ready_o, register sh_q=sh_i and go to SHIFT_GEN.
  - sh_ready_o drops in the following cycle.
- SHIFT_GEN (exactly 1 cycle):
  - isGtr_o = (delta_q > sh_q); isGtr_vld_o=1.
  - Register shift_o = isGtr ? (sh_q + Z - delta_q) : (sh_q - delta_q). Compute with SHIFT_W+1 bits; the result is always in [0, Z-1].
  - Set shift_valid_o=1 and go to OUT_WAIT.
- Delta FF:
  - Load delta_q <= sh_q on the SHIFT_GEN exit edge.
  - On any edge where delta_rst_i==RST_POLARITY, delta_q <= 0. This clear has priority over the SHIFT_GEN load when both occur on the same edge.
  - delta_q is not cleared by start_i; it carries across layers unless delta_rst_i clears it.
- OUT_WAIT:
  - Hold shift_o and shift_valid_o stable until shift_ready_i=1.
  - On acceptance, increment the counter.
  - If counter+1==col_num: pulse done_o, drop shift_valid_o, go to IDLE.
  - Otherwise drop shift_valid_o and go to READ_COL_ADDR.
- Latency: sh_i accepted at edge N → isGtr_vld_o high during cycle N+1 → shift_valid_o high from N+2. Minimum 3 cycles per column with shift_ready_i tied high.
- Edge values:
  - sh_q == delta_q gives isGtr=0 and shift 0.
  - delta_q=Z-1, sh_q=0 gives isGtr=1 and shift 1.
- col_num_i > COL_MAX: behaviour is unspecified; the bench flags it with an assertion.

Test Plan:
1. Z=255, reset, delta_rst_i held inactive, start col_num=3, sh=10,40,5 with ready high → isGtr 0,0,1; shift_o 10,30,220; done_o one cycle after the third handshake; delta_q=5.
2. delta_q=254, sh=0 → isGtr_o=1, shift_o=1. Then sh=254 → isGtr_o=0, shift_o=254.
3. Backpressure: hold shift_ready_i=0 for 5 cycles in OUT_WAIT → shift_o/shift_valid_o stable and sh_ready_o=0 throughout; acceptance resumes next column.
4. delta_rst_i asserted on the same edge as the SHIFT_GEN exit with sh=77 → delta_q=0; next sh=77 gives shift_o=77, isGtr_o=0.
5. rstn low while in OUT_WAIT (col 2 of 4) → next cycle in IDLE, all outputs 0, no done_o; a new start then runs cleanly.
6. start_i with col_num_i=0 → done_o pulse, busy_o stays 0, sh_ready_o never asserts.
